// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Selector codes follow the {funct7,funct3} layout.
package alu_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] SEL_ADD = 10'h000;
    localparam logic [SEL_W-1:0] SEL_SUB = 10'h100;
    localparam logic [SEL_W-1:0] SEL_SLL = 10'h001;
    localparam logic [SEL_W-1:0] SEL_SRL = 10'h005;
    localparam logic [SEL_W-1:0] SEL_SRA = 10'h105;
    localparam logic [SEL_W-1:0] SEL_XOR = 10'h004;
    localparam logic [SEL_W-1:0] SEL_OR  = 10'h006;
    localparam logic [SEL_W-1:0] SEL_AND = 10'h007;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters/consumer (master) and the arbiter (slave).
interface alu_arbiter_if;
    import alu_arbiter_pkg::*;

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req0_in0;
    logic [DATA_W-1:0] req0_in1;
    logic [SEL_W-1:0]  req0_selector;
    logic [DATA_W-1:0] req1_in0;
    logic [DATA_W-1:0] req1_in1;
    logic [SEL_W-1:0]  req1_selector;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_out;
    logic              rsp_zero;
    logic              busy;

    modport master (
        output req_valid, req0_in0, req0_in1, req0_selector,
               req1_in0, req1_in1, req1_selector, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_zero, busy
    );

    modport slave (
        input  req_valid, req0_in0, req0_in1, req0_selector,
               req1_in0, req1_in1, req1_selector, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_out, rsp_zero, busy
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU shared by both requesters.
// Undecoded selectors return in0 unchanged.
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [SEL_W-1:0]  selector,
    output logic [DATA_W-1:0] result
);

    logic [4:0] shamt;
    assign shamt = in1[4:0];

    always_comb begin
        result = in0;
        case (selector)
            SEL_ADD: result = in0 + in1;
            SEL_SUB: result = in0 - in1;
            SEL_SLL: result = in0 << shamt;
            SEL_SRL: result = in0 >> shamt;
            SEL_SRA: result = $unsigned($signed(in0) >>> shamt);
            SEL_XOR: result = in0 ^ in1;
            SEL_OR:  result = in0 | in1;
            SEL_AND: result = in0 & in1;
            default: result = in0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU: IDLE grant, EXEC compute, RESP hold.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority (requester 0).
//
// state | meaning
// IDLE  | arbitrate, grant and latch one request
// EXEC  | latched operands drive the ALU, result captured at the edge
// RESP  | result presented until rsp_ready
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    state_t            state;
    logic [DATA_W-1:0] op_in0;
    logic [DATA_W-1:0] op_in1;
    logic [SEL_W-1:0]  op_sel;
    logic              op_id;
    logic [DATA_W-1:0] alu_result;
    logic              grant_any;
    logic              grant_id;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic last_id;

    always_comb begin
        grant_id = bus.req_valid[1];
        if (bus.req_valid == 2'b11)
            grant_id = ~last_id;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_id <= 1'b1;
        else if (grant_any)
            last_id <= grant_id;
    end
`else
    assign grant_id = ~bus.req_valid[0];
`endif

    // Gated by rst so req_ready reads zero while reset is held.
    assign grant_any     = (state == ST_IDLE) && !rst && (bus.req_valid != 2'b00);
    assign bus.req_ready = grant_any ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

    alu u_alu (
        .in0      (op_in0),
        .in1      (op_in1),
        .selector (op_sel),
        .result   (alu_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            op_in0        <= '0;
            op_in1        <= '0;
            op_sel        <= '0;
            op_id         <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_out   <= '0;
            bus.rsp_zero  <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        op_in0   <= grant_id ? bus.req1_in0      : bus.req0_in0;
                        op_in1   <= grant_id ? bus.req1_in1      : bus.req0_in1;
                        op_sel   <= grant_id ? bus.req1_selector : bus.req0_selector;
                        op_id    <= grant_id;
                        bus.busy <= 1'b1;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    bus.rsp_out   <= alu_result;
                    bus.rsp_zero  <= (alu_result == '0);
                    bus.rsp_id    <= op_id;
                    bus.rsp_valid <= 1'b1;
                    state         <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    bus.rsp_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized operations
// against a behavioural model of arbitration and ALU arithmetic.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic model_last;

    alu_arbiter_if bus();

    alu_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [9:0] sel);
        int unsigned sh;
        logic [31:0] fill;
        sh = b % 32;
        fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
        case (sel)
            SEL_ADD: return a + b;
            SEL_SUB: return a + (~b) + 32'd1;
            SEL_SLL: return a * (32'd1 << sh);
            SEL_SRL: return a / (32'd1 << sh);
            SEL_SRA: return (a / (32'd1 << sh)) | fill;
            SEL_XOR: return (a | b) & ~(a & b);
            SEL_OR:  return a | b;
            SEL_AND: return a & b;
            default: return a;
        endcase
    endfunction

    function automatic logic ref_grant(input logic [1:0] v);
        if (v == 2'b01) return 1'b0;
        if (v == 2'b10) return 1'b1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        return ~model_last;
`else
        return 1'b0;
`endif
    endfunction

    // Called a little after a posedge while the DUT sits in IDLE; returns likewise.
    task automatic issue(input logic [1:0] v,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [9:0] s0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [9:0] s1,
                         input int stall, input bit keep, input string tag);
        logic        gid;
        logic [31:0] exp;
        bus.req_valid     = v;
        bus.req0_in0      = a0;
        bus.req0_in1      = b0;
        bus.req0_selector = s0;
        bus.req1_in0      = a1;
        bus.req1_in1      = b1;
        bus.req1_selector = s1;
        bus.rsp_ready     = (stall == 0);
        gid = ref_grant(v);
        exp = gid ? ref_alu(a1, b1, s1) : ref_alu(a0, b0, s0);
        @(negedge clk);
        chk({tag, " idle req_ready"}, {30'h0, bus.req_ready}, gid ? 32'h2 : 32'h1);
        chk({tag, " idle busy"}, {31'h0, bus.busy}, 32'h0);
        @(posedge clk); #1;
        model_last = gid;
        if (!keep) bus.req_valid = 2'b00;
        @(negedge clk);
        chk({tag, " exec busy"}, {31'h0, bus.busy}, 32'h1);
        chk({tag, " exec rsp_valid"}, {31'h0, bus.rsp_valid}, 32'h0);
        chk({tag, " exec req_ready"}, {30'h0, bus.req_ready}, 32'h0);
        @(negedge clk);
        chk({tag, " rsp_valid"}, {31'h0, bus.rsp_valid}, 32'h1);
        chk({tag, " rsp_out"}, bus.rsp_out, exp);
        chk({tag, " rsp_zero"}, {31'h0, bus.rsp_zero}, {31'h0, exp == 32'h0});
        chk({tag, " rsp_id"}, {31'h0, bus.rsp_id}, {31'h0, gid});
        chk({tag, " resp req_ready"}, {30'h0, bus.req_ready}, 32'h0);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk({tag, " stall rsp_valid"}, {31'h0, bus.rsp_valid}, 32'h1);
            chk({tag, " stall rsp_out"}, bus.rsp_out, exp);
            chk({tag, " stall rsp_id"}, {31'h0, bus.rsp_id}, {31'h0, gid});
            chk({tag, " stall req_ready"}, {30'h0, bus.req_ready}, 32'h0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [9:0]  sels [9];
        logic [31:0] ra0, rb0, ra1, rb1;
        logic [9:0]  rs0, rs1;
        logic [1:0]  rv;

        checks = 0;
        errors = 0;
        model_last = 1'b1;
        sels = '{SEL_ADD, SEL_SUB, SEL_SLL, SEL_SRL, SEL_SRA, SEL_XOR, SEL_OR, SEL_AND, 10'h3FF};

        rst = 1'b1;
        bus.req_valid = 2'b11;
        bus.req0_in0 = 32'h0; bus.req0_in1 = 32'h0; bus.req0_selector = SEL_ADD;
        bus.req1_in0 = 32'h0; bus.req1_in1 = 32'h0; bus.req1_selector = SEL_ADD;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", {30'h0, bus.req_ready}, 32'h0);
        chk("reset rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("reset rsp_out", bus.rsp_out, 32'h0);
        chk("reset rsp_zero", {31'h0, bus.rsp_zero}, 32'h0);
        chk("reset rsp_id", {31'h0, bus.rsp_id}, 32'h0);
        chk("reset busy", {31'h0, bus.busy}, 32'h0);
        bus.req_valid = 2'b00;
        rst = 1'b0;
        @(posedge clk); #1;

        issue(2'b01, 32'd5, 32'd7, SEL_ADD, 32'd0, 32'd0, SEL_ADD, 0, 0, "add5_7");
        issue(2'b10, 32'd0, 32'd0, SEL_ADD, 32'd9, 32'd9, SEL_SUB, 0, 0, "sub9_9");

        for (int i = 0; i < 4; i++)
            issue(2'b11, 32'd100 + i, 32'd1, SEL_ADD, 32'd200 + i, 32'd2, SEL_SUB, 0, 1, "tie");
        bus.req_valid = 2'b00;

        issue(2'b01, 32'h1234_5678, 32'h0F0F_0F0F, SEL_XOR, 32'h0, 32'h0, SEL_ADD, 4, 0, "stall");
        issue(2'b01, 32'h8000_0000, 32'd4, SEL_SRA, 32'h0, 32'h0, SEL_ADD, 0, 0, "sra");

        bus.req_valid = 2'b01;
        bus.req0_in0 = 32'd3; bus.req0_in1 = 32'd4; bus.req0_selector = SEL_ADD;
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        rst = 1'b1;
        #1;
        chk("rst exec rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("rst exec busy", {31'h0, bus.busy}, 32'h0);
        chk("rst exec rsp_out", bus.rsp_out, 32'h0);
        chk("rst exec rsp_zero", {31'h0, bus.rsp_zero}, 32'h0);
        chk("rst exec rsp_id", {31'h0, bus.rsp_id}, 32'h0);
        chk("rst exec req_ready", {30'h0, bus.req_ready}, 32'h0);
        model_last = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post rst rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
            chk("post rst busy", {31'h0, bus.busy}, 32'h0);
        end
        @(posedge clk); #1;
        issue(2'b01, 32'd40, 32'd2, SEL_SLL, 32'h0, 32'h0, SEL_ADD, 0, 0, "after rst");

        for (int n = 0; n < 30; n++) begin
            rv  = 2'($urandom_range(1, 3));
            ra0 = $urandom; rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
            ra1 = $urandom; rb1 = ($urandom_range(0, 3) == 0) ? ra1 : $urandom;
            rs0 = sels[$urandom_range(0, 8)];
            rs1 = sels[$urandom_range(0, 8)];
            issue(rv, ra0, rb0, rs0, ra1, rb1, rs1, $urandom_range(0, 2), 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters: none; data width fixed at 32 bits, selector width fixed at 10 bits.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  2  bit i: requester i presents an operation.
REQ-005 req_ready  output  2  bit i: requester i's operation accepted this cycle.
REQ-006 req0_in0, req0_in1  input  32 each  requester 0 operands.
REQ-007 req0_selector  input  10  requester 0 operation code ({funct7,funct3} layout).
REQ-008 req1_in0, req1_in1, req1_selector  input  32/32/10  requester 1 equivalents.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes result.
REQ-011 rsp_id  output  1  index of requester owning the result.
REQ-012 rsp_out  output  32  ALU result.
REQ-013 rsp_zero  output  1  high when rsp_out == 0.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states IDLE, EXEC, RESP, each held at least one cycle.
REQ-016 IDLE: if any req_valid bit set, grant one requester, assert its req_ready combinationally in that cycle, latch its in0/in1/selector and id at the clock edge, go to EXEC; otherwise stay in IDLE.
REQ-017 req_ready is zero outside IDLE and never has both bits set.
REQ-018 Requesters hold valid and operands stable until ready; dropping req_valid before ready withdraws the request without error.
REQ-019 EXEC: drive the latched operands into the shared ALU; at the clock edge register its output into rsp_out, register (result == 0) into rsp_zero, go to RESP.
REQ-020 RESP: rsp_valid high; rsp_out, rsp_zero and rsp_id stay stable while rsp_ready is low; on rsp_valid && rsp_ready go to IDLE.
REQ-021 Latency: acceptance edge at cycle t gives rsp_valid high in cycle t+2; peak throughput is one operation per 3 cycles when rsp_ready is held high.
REQ-022 Selector values the ALU does not decode pass through unchanged; the result is whatever the ALU returns (in0 passthrough); the arbiter never flags these.
REQ-023 A new grant is never made in the cycle a response completes; arbitration resumes in the following IDLE cycle.

Reset
REQ-024 While rst is high: state = IDLE; rsp_valid, rsp_id, rsp_out, rsp_zero, busy and req_ready = 0; latched operands = 0; last-grant pointer = 1.
REQ-025 Reset asserted in EXEC or RESP discards the in-flight operation with no response issued; after rst falls, the first cycle is IDLE.

Configuration
REQ-026 Macro ALU_ARB_ROUND_ROBIN_EN defined: when both requests are valid, the grant goes to the requester not granted last; the last-grant pointer updates on every grant.
REQ-027 Macro ALU_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins a tie; the pointer is not implemented.
REQ-028 With a single valid requester, both builds grant that requester.

Structure
REQ-029 A shared package/include holds the FSM state encodings, the selector constants (ADD, SUB, SLL, SRL, SRA, XOR, OR, AND) and the width constants (32, 10).
REQ-030 The existing alu module is instantiated once as the only sub-module; its output feeds the EXEC capture register.

Verification
REQ-031 req0: in0=5, in1=7, selector=ADD, rsp_ready=1 -> rsp_valid in cycle t+2 with rsp_out=12, rsp_zero=0, rsp_id=0.
REQ-032 req1: in0=9, in1=9, selector=SUB -> rsp_out=0, rsp_zero=1, rsp_id=1.
REQ-033 Both requesters valid continuously, round-robin build -> rsp_id sequence 0,1,0,1; fixed-priority build -> 0,0,0,0.
REQ-034 rsp_ready held low 4 cycles in RESP -> rsp_valid stays high, rsp_out stable, req_ready stays 0 throughout.
REQ-035 rst pulsed during EXEC -> all outputs 0 at once; no response afterward; the next request completes normally with correct data.
REQ-036 req0: in0=32'h80000000, in1=4, selector=SRA -> rsp_out=32'hF8000000.
